// File: rtl/prog_loader.sv
// UART (8N1, LSB first) program loader: fills program RAM addresses 0..DEPTH-1
// in order while load_mode is high, holding the CPU in clear throughout.
module prog_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH        = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rx,
  input  logic       load_mode,
  output logic       cpu_hold,
  output logic       ram_we,
  output logic [3:0] ram_addr,
  output logic [7:0] ram_data,
  output logic       busy,
  output logic       done,
  output logic       frame_err,
  output logic [2:0] dbg_state
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_FULL = BW'(CLKS_PER_BIT - 1);
  // Detect cycle plus START countdown together span CLKS_PER_BIT/2 cycles.
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 2);
  localparam logic [3:0]    LAST_ADDR = 4'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_WRITE = 3'd4,
    S_FULL  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [3:0]      addr_q, addr_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            rx_s1_q, rx_s2_q;
  logic            lm_q;
  logic            rxs;
  logic            lm_rise;

  assign rxs     = rx_s2_q;
  assign lm_rise = load_mode & ~lm_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      lm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      rx_s1_q <= rx;
      rx_s2_q <= rx_s1_q;
      lm_q    <= load_mode;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    done_d  = done_q;
    ferr_d  = ferr_q;
    if (lm_rise) begin
      addr_d = '0;
      done_d = 1'b0;
      ferr_d = 1'b0;
    end
    if (!load_mode) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // A session restart in this cycle wins over a coincident start bit.
          if (!lm_rise && !done_q && !rxs) begin
            state_d = S_START;
            baud_d  = BAUD_HALF;
          end
        end
        S_START: begin
          if (baud_q == '0) begin
            state_d = rxs ? S_IDLE : S_DATA;
            baud_d  = BAUD_FULL;
            bit_d   = '0;
          end else begin
            baud_d = baud_q - 1'b1;
          end
        end
        S_DATA: begin
          if (baud_q == '0) begin
            shift_d = {rxs, shift_q[7:1]};
            baud_d  = BAUD_FULL;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = S_STOP;
          end else begin
            baud_d = baud_q - 1'b1;
          end
        end
        S_STOP: begin
          if (baud_q == '0) begin
            if (rxs) begin
              state_d = S_WRITE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            baud_d = baud_q - 1'b1;
          end
        end
        S_WRITE: begin
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            done_d  = 1'b1;
            state_d = S_FULL;
          end else begin
            addr_d  = addr_q + 4'd1;
            state_d = S_IDLE;
          end
        end
        S_FULL:  state_d = S_FULL;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ram_we is a single-cycle strobe; ram_addr/ram_data are valid for exactly
  // that cycle and the RAM has no way to stall it.
  always_comb begin
    cpu_hold  = load_mode;
    ram_we    = (state_q == S_WRITE) && load_mode;
    busy      = (state_q == S_START) || (state_q == S_DATA) ||
                (state_q == S_STOP)  || (state_q == S_WRITE);
    ram_addr  = addr_q;
    ram_data  = shift_q;
    done      = done_q;
    frame_err = ferr_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader: drives UART frames and
// compares RAM writes and status flags against a byte-level session model.
module tb_prog_loader;
  localparam int CPB   = 8;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       clr;
  logic       rx;
  logic       load_mode;
  logic       cpu_hold;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       busy;
  logic       done;
  logic       frame_err;
  logic [2:0] dbg_state;

  prog_loader #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .rx(rx), .load_mode(load_mode),
    .cpu_hold(cpu_hold), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_data(ram_data), .busy(busy), .done(done), .frame_err(frame_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // scoreboard: {addr, data} of every write
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  logic [11:0] e, o;
  int   start_cyc;
  int   we_cyc;
  logic prev_we = 1'b0;

  // reference model state for the current session
  int m_addr;
  bit m_done;
  bit m_ferr;

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      obs_q.push_back({ram_addr, ram_data});
      we_cyc = cyc;
      checks++;
      if (prev_we || !load_mode) begin
        errors++;
        $display("FAIL strobe: prev_we=%0b load_mode=%0b, required single-cycle strobe with load_mode=1",
                 prev_we, load_mode);
      end
    end
    prev_we = ram_we;
  end

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!m_done) begin
      if (ok) begin
        exp_q.push_back({4'(m_addr), b});
        m_addr++;
        if (m_addr == DEPTH) begin
          m_addr = 0;
          m_done = 1;
        end
      end else begin
        m_ferr = 1;
      end
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit ok);
    @(negedge clk);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (ok) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (CPB / 2 + 2) @(negedge clk);
      rx = 1'b1;
      repeat (CPB / 2 - 2) @(negedge clk);
    end
    repeat (2 * CPB) @(negedge clk);
    if (load_mode) model_byte(b, ok);
  endtask

  task automatic new_session();
    load_mode = 1'b0;
    repeat (3) @(negedge clk);
    load_mode = 1'b1;
    m_addr = 0;
    m_done = 0;
    m_ferr = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    clr = 1'b1; rx = 1'b1; load_mode = 1'b0;
    #2;
    checks++; if (ram_we !== 1'b0)    begin errors++; $display("FAIL reset_we: got %b, required 0", ram_we); end
    checks++; if (ram_addr !== 4'd0)  begin errors++; $display("FAIL reset_addr: got %0d, required 0", ram_addr); end
    checks++; if (ram_data !== 8'd0)  begin errors++; $display("FAIL reset_data: got %02h, required 00", ram_data); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b, required 0", frame_err); end
    checks++; if (cpu_hold !== 1'b0)  begin errors++; $display("FAIL reset_hold: got %b, required 0", cpu_hold); end
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fill();
    new_session();
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL fill_hold: got %b, required 1", cpu_hold); end
    for (int k = 0; k < DEPTH; k++) send_byte(8'(k), 1'b1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL fill_count: got %0d writes, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL fill_write: got addr=%0d data=%02h, required addr=%0d data=%02h", o[11:8], o[7:0], e[11:8], e[7:0]); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (done !== m_done)           begin errors++; $display("FAIL fill_done: got %b, required %b", done, m_done); end
    checks++; if (ram_addr !== 4'(m_addr))   begin errors++; $display("FAIL fill_addr: got %0d, required %0d", ram_addr, m_addr); end
    checks++; if (frame_err !== m_ferr)      begin errors++; $display("FAIL fill_ferr: got %b, required %b", frame_err, m_ferr); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [2];
    bytes[0] = 8'hA5; bytes[1] = 8'h3C;
    new_session();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL session_done_clear: got %b, required 0", done); end
    for (int k = 0; k < 2; k++) begin
      we_cyc = -1;
      send_byte(bytes[k], 1'b1);
      checks++;
      if (we_cyc - start_cyc < 76 || we_cyc - start_cyc > 78) begin
        errors++; $display("FAIL latency: got %0d cycles, required 77 +/-1", we_cyc - start_cyc);
      end
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d writes, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_write: got addr=%0d data=%02h, required addr=%0d data=%02h", o[11:8], o[7:0], e[11:8], e[7:0]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_frame_err();
    new_session();
    send_byte(8'h55, 1'b0);
    checks++; if (frame_err !== m_ferr) begin errors++; $display("FAIL ferr_set: got %b, required %b", frame_err, m_ferr); end
    send_byte(8'h77, 1'b1);
    checks++; if (frame_err !== m_ferr) begin errors++; $display("FAIL ferr_sticky: got %b, required %b", frame_err, m_ferr); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL ferr_count: got %0d writes, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL ferr_write: got addr=%0d data=%02h, required addr=%0d data=%02h", o[11:8], o[7:0], e[11:8], e[7:0]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_glitch();
    new_session();
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (CPB + 2) @(negedge clk);
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL glitch_busy: got %b, required 0", busy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_ferr: got %b, required 0", frame_err); end
    checks++; if (obs_q.size() != 0)  begin errors++; $display("FAIL glitch_write: got %0d writes, required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_abort();
    logic [7:0] b;
    new_session();
    for (int k = 0; k < 2; k++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    b = 8'($urandom_range(0, 255));
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == 4) begin
        repeat (CPB / 2) @(negedge clk);
        load_mode = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL abort_busy: got %b, required 0", busy); end
        checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL abort_hold: got %b, required 0", cpu_hold); end
        repeat (CPB / 2 - 1) @(negedge clk);
      end else begin
        repeat (CPB) @(negedge clk);
      end
    end
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checks++; if (ram_addr !== 4'(m_addr)) begin errors++; $display("FAIL abort_addr: got %0d, required %0d", ram_addr, m_addr); end
    load_mode = 1'b1;
    m_addr = 0; m_done = 0; m_ferr = 0;
    repeat (3) @(negedge clk);
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rearm_hold: got %b, required 1", cpu_hold); end
    send_byte(8'hEE, 1'b1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_count: got %0d writes, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL abort_write: got addr=%0d data=%02h, required addr=%0d data=%02h", o[11:8], o[7:0], e[11:8], e[7:0]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_random();
    new_session();
    for (int k = 0; k < 6; k++)
      send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0));
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d writes, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL rand_write: got addr=%0d data=%02h, required addr=%0d data=%02h", o[11:8], o[7:0], e[11:8], e[7:0]); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (ram_addr !== 4'(m_addr)) begin errors++; $display("FAIL rand_addr: got %0d, required %0d", ram_addr, m_addr); end
    checks++; if (frame_err !== m_ferr)    begin errors++; $display("FAIL rand_ferr: got %b, required %b", frame_err, m_ferr); end
  endtask

  task automatic test_full_clr();
    new_session();
    for (int k = 0; k < DEPTH; k++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    send_byte(8'hFF, 1'b1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL full_count: got %0d writes, required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL full_write: got addr=%0d data=%02h, required addr=%0d data=%02h", o[11:8], o[7:0], e[11:8], e[7:0]); end
    end
    exp_q.delete(); obs_q.delete();
    checks++; if (done !== 1'b1)      begin errors++; $display("FAIL full_done: got %b, required 1", done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL full_ferr: got %b, required 0", frame_err); end

    new_session();
    send_byte(8'h81, 1'b1);
    send_byte(8'h55, 1'b0);
    exp_q.delete(); obs_q.delete();
    @(negedge clk);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_pre_busy: got %b, required 1", busy); end
    #2 clr = 1'b1;
    #1;
    checks++; if (ram_we !== 1'b0)    begin errors++; $display("FAIL clr_we: got %b, required 0", ram_we); end
    checks++; if (ram_addr !== 4'd0)  begin errors++; $display("FAIL clr_addr: got %0d, required 0", ram_addr); end
    checks++; if (ram_data !== 8'd0)  begin errors++; $display("FAIL clr_data: got %02h, required 00", ram_data); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL clr_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL clr_done: got %b, required 0", done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL clr_ferr: got %b, required 0", frame_err); end
    rx = 1'b1;
    load_mode = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL clr_write: got %0d writes, required 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_abort();
    test_random();
    test_full_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
